aexm_ifetch: RTL

Instruction-fetch responder sitting on the far end of the core's early fetch-address path. It accepts the word address the branch/PC unit issues one cycle ahead, answers with the instruction word on the following cycle from a direct-mapped instruction cache, and on a miss stalls the core while it refills one line from memory over a simple request/acknowledge bus. It also provides whole-cache invalidation by a valid-bit sweep.

---
 rtl/aexm_ifetch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aexm_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aexm_ifetch                                                     |
// | Brief    : Direct-mapped instruction cache answering the early fetch       |
// |            address one cycle later; single-line refill and valid sweep.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module aexm_ifetch #(
  parameter int IW         = 24,
  parameter int LINES_LOG2 = 6,
  parameter int WORDS_LOG2 = 2
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic [IW-3:0] aexm_icache_precycle_addr,
  input  logic          ic_inval,
  output logic [31:0]   rINST,
  output logic          ic_busy,
  output logic          mem_req,
  output logic [IW-3:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_data
);

  localparam int AW      = IW - 2;
  localparam int DW_LOG2 = LINES_LOG2 + WORDS_LOG2;
  localparam int TW      = AW - DW_LOG2;
  localparam int LINES   = 1 << LINES_LOG2;

  localparam logic [1:0] c_flush  = 2'd0;
  localparam logic [1:0] c_idle   = 2'd1;
  localparam logic [1:0] c_refill = 2'd2;
  localparam logic [1:0] c_filled = 2'd3;

  localparam logic [WORDS_LOG2-1:0] c_beat_one  = 1;
  localparam logic [WORDS_LOG2-1:0] c_beat_last = '1;
  localparam logic [LINES_LOG2:0]   c_sweep_one = 1;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic                  invq_q, invq_d;
  logic [WORDS_LOG2-1:0] beat_q, beat_d;
  logic [LINES_LOG2:0]   sweep_q, sweep_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [31:0]           bypass_q, bypass_d;

  logic [31:0]           data_mem [2**DW_LOG2];
  logic [TW-1:0]         tag_mem  [LINES];
  logic [31:0]           data_rd_q;
  logic [TW-1:0]         tag_rd_q;

  logic                  w_capture;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill_we;
  logic [DW_LOG2-1:0]    w_rd_line;
  logic [WORDS_LOG2-1:0] w_cur_off;
  logic [LINES_LOG2-1:0] w_cur_idx;
  logic [TW-1:0]         w_cur_tag;

  assign w_cur_off = addr_q[WORDS_LOG2-1:0];
  assign w_cur_idx = addr_q[DW_LOG2-1:WORDS_LOG2];
  assign w_cur_tag = addr_q[AW-1:DW_LOG2];

  assign w_hit     = pend_q & valid_q[w_cur_idx] & (tag_rd_q == w_cur_tag);
  assign w_miss    = (state_q == c_idle) & pend_q & ~w_hit;
  assign ic_busy   = (state_q == c_flush) | (state_q == c_refill) | w_miss;
  assign w_capture = gena & ~ic_busy;
  assign w_fill_we = (state_q == c_refill) & mem_ack;

  // Without a capture the held address is re-read, so the line written by a
  // refill is visible once FILLED hands back to IDLE.
  assign w_rd_line = w_capture ? aexm_icache_precycle_addr[DW_LOG2-1:0]
                               : addr_q[DW_LOG2-1:0];

  assign mem_req  = (state_q == c_refill);
  assign mem_addr = mem_req ? {addr_q[AW-1:WORDS_LOG2], beat_q} : '0;

  always_comb begin
    rINST = 32'h0;
    if (state_q == c_filled) begin
      rINST = bypass_q;
    end else if ((state_q == c_idle) && w_hit) begin
      rINST = data_rd_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    invq_d   = invq_q | ic_inval;
    beat_d   = beat_q;
    sweep_d  = sweep_q;
    valid_d  = valid_q;
    bypass_d = bypass_q;
    if (w_capture) begin
      addr_d = aexm_icache_precycle_addr;
      pend_d = 1'b1;
    end
    case (state_q)
      c_flush: begin
        pend_d = 1'b0;
        invq_d = 1'b0;
        valid_d[sweep_q[LINES_LOG2-1:0]] = 1'b0;
        if (ic_inval) begin
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + c_sweep_one;
          if (sweep_d[LINES_LOG2]) begin
            sweep_d = '0;
            state_d = c_idle;
          end
        end
      end
      c_idle: begin
        // A pending miss is served before an invalidate so the stalled fetch
        // still receives its word.
        if (w_miss) begin
          state_d = c_refill;
          beat_d  = '0;
        end else if (invq_q) begin
          state_d = c_flush;
          invq_d  = 1'b0;
        end
      end
      c_refill: begin
        if (mem_ack) begin
          beat_d = beat_q + c_beat_one;
          if (beat_q == w_cur_off) begin
            bypass_d = mem_data;
          end
          if (beat_q == c_beat_last) begin
            valid_d[w_cur_idx] = 1'b1;
            state_d            = c_filled;
          end
        end
      end
      c_filled: begin
        if (invq_q) begin
          state_d = c_flush;
          invq_d  = 1'b0;
        end else begin
          state_d = c_idle;
        end
      end
      default: state_d = c_flush;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q  <= c_flush;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      invq_q   <= 1'b0;
      beat_q   <= '0;
      sweep_q  <= '0;
      bypass_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      invq_q   <= invq_d;
      beat_q   <= beat_d;
      sweep_q  <= sweep_d;
      valid_q  <= valid_d;
      bypass_q <= bypass_d;
    end
  end

  always_ff @(posedge gclk) begin
    data_rd_q <= data_mem[w_rd_line];
    tag_rd_q  <= tag_mem[w_rd_line[DW_LOG2-1:WORDS_LOG2]];
    if (w_fill_we) begin
      data_mem[{w_cur_idx, beat_q}] <= mem_data;
    end
    if (w_fill_we && (beat_q == c_beat_last)) begin
      tag_mem[w_cur_idx] <= w_cur_tag;
    end
  end

endmodule
`default_nettype wire
